// File: rtl/storage_rr_mem.sv
// ---------------------------------------------------------------------------
// storage_rr_mem
//   Single-write, multi-read row memory. Read channels are arbitrated
//   round-robin: at most one channel is granted per cycle. After every reset
//   the array is zero-filled before any traffic is accepted.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           asynchronous reset, active-low
//   readAddrs     packed per-channel row addresses; channel i is at
//                 [i*READ_ADDR_SIZE +: READ_ADDR_SIZE]
//   readReqs      per-channel read request, held until granted
//   readfin       one-hot grant, combinational, same cycle as the request
//   readValid     one-hot, registered copy of readfin; owner of poolReadData
//   poolReadData  registered read data
//   writeAddr     write row address
//   writeData     write data
//   writeMask     byte enables; bit b covers byte b
//   writeEn       write strobe
//   ready         high once the zero-fill has finished
//
// States
//   ST_INIT | zero-fill one row per cycle; reads and writes are dropped
//   ST_RUN  | normal operation: arbitrated reads, masked writes
// ---------------------------------------------------------------------------
module storage_rr_mem #(
    parameter int READ_ADDR_SIZE = 6,
    parameter int ROW_WIDTH      = 32,
    parameter int AMT_READER     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [READ_ADDR_SIZE*AMT_READER-1:0] readAddrs,
    input  logic [AMT_READER-1:0]                readReqs,
    output logic [AMT_READER-1:0]                readfin,
    output logic [AMT_READER-1:0]                readValid,
    output logic [ROW_WIDTH-1:0]                 poolReadData,
    input  logic [READ_ADDR_SIZE-1:0]            writeAddr,
    input  logic [ROW_WIDTH-1:0]                 writeData,
    input  logic [ROW_WIDTH/8-1:0]               writeMask,
    input  logic                                 writeEn,
    output logic                                 ready
);

    localparam int DEPTH = 1 << READ_ADDR_SIZE;
    localparam int BYTES = ROW_WIDTH / 8;
    localparam int PTR_W = $clog2(AMT_READER);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [READ_ADDR_SIZE-1:0]   init_ptr_q, init_ptr_d;
    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [AMT_READER-1:0]       valid_q, valid_d;
    logic [ROW_WIDTH-1:0]        rd_data_q, rd_data_d;

    logic [ROW_WIDTH-1:0]        mem_q [DEPTH];

    logic                        mem_we;
    logic [READ_ADDR_SIZE-1:0]   mem_waddr;
    logic [ROW_WIDTH-1:0]        mem_wdata;
    logic [ROW_WIDTH-1:0]        merged_row;
    logic [AMT_READER-1:0]       grant;
    logic                        gnt_found;
    int                          gnt_idx;
    int                          scan_idx;
    logic [READ_ADDR_SIZE-1:0]   rd_addr;

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        rr_ptr_d   = rr_ptr_q;
        valid_d    = '0;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;
        mem_waddr  = init_ptr_q;
        mem_wdata  = '0;
        grant      = '0;
        gnt_found  = 1'b0;
        gnt_idx    = 0;
        scan_idx   = 0;
        rd_addr    = '0;

        // Row as it will look after this cycle's masked write; also the
        // bypass value for a same-cycle read of the written row.
        merged_row = mem_q[writeAddr];
        for (int b = 0; b < BYTES; b++) begin
            if (writeMask[b]) begin
                merged_row[b*8 +: 8] = writeData[b*8 +: 8];
            end
        end

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                init_ptr_d = init_ptr_q + READ_ADDR_SIZE'(1);
                if (init_ptr_q == READ_ADDR_SIZE'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // First requester at or after rr_ptr_q, wrapping round.
                for (int k = 0; k < AMT_READER; k++) begin
                    scan_idx = (int'(rr_ptr_q) + k) % AMT_READER;
                    if (!gnt_found && readReqs[scan_idx]) begin
                        gnt_found = 1'b1;
                        gnt_idx   = scan_idx;
                    end
                end

                if (writeEn) begin
                    mem_we    = 1'b1;
                    mem_waddr = writeAddr;
                    mem_wdata = merged_row;
                end

                if (gnt_found) begin
                    grant[gnt_idx] = 1'b1;
                    valid_d        = grant;
                    rr_ptr_d       = PTR_W'((gnt_idx + 1) % AMT_READER);
                    rd_addr        = readAddrs[gnt_idx*READ_ADDR_SIZE +: READ_ADDR_SIZE];
                    if (writeEn && (rd_addr == writeAddr)) begin
                        rd_data_d = merged_row;
                    end else begin
                        rd_data_d = mem_q[rd_addr];
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            rr_ptr_q   <= '0;
            valid_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rr_ptr_q   <= rr_ptr_d;
            valid_q    <= valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Array contents are defined by the zero-fill, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign readfin      = grant;
    assign readValid    = valid_q;
    assign poolReadData = rd_data_q;
    assign ready        = (state_q == ST_RUN);

endmodule

// File: tb/tb_storage_rr_mem.sv
module tb_storage_rr_mem;

    localparam int RAS = 6;
    localparam int RW  = 32;
    localparam int N   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [RAS*N-1:0] readAddrs;
    logic [N-1:0]    readReqs;
    logic [N-1:0]    readfin;
    logic [N-1:0]    readValid;
    logic [RW-1:0]   poolReadData;
    logic [RAS-1:0]  writeAddr;
    logic [RW-1:0]   writeData;
    logic [RW/8-1:0] writeMask;
    logic            writeEn;
    logic            ready;

    storage_rr_mem #(
        .READ_ADDR_SIZE(RAS),
        .ROW_WIDTH     (RW),
        .AMT_READER    (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .readAddrs   (readAddrs),
        .readReqs    (readReqs),
        .readfin     (readfin),
        .readValid   (readValid),
        .poolReadData(poolReadData),
        .writeAddr   (writeAddr),
        .writeData   (writeData),
        .writeMask   (writeMask),
        .writeEn     (writeEn),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [RW-1:0] mem_m [64];
    int            rr_m;
    logic [RW-1:0] last_m;

    typedef struct {
        logic [3:0]  reqs;
        logic [23:0] addrs;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [3:0]  efin;
        logic [3:0]  evalid;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [23:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] reqs, input logic [23:0] addrs,
                                input logic we, input logic [5:0] wa, input logic [31:0] wd,
                                input logic [3:0] wm, input logic [3:0] efin,
                                input logic [3:0] evalid, input logic [31:0] edata);
        vec_t v;
        v.reqs = reqs; v.addrs = addrs; v.we = we; v.wa = wa; v.wd = wd; v.wm = wm;
        v.efin = efin; v.evalid = evalid; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        readReqs  = '0;
        readAddrs = '0;
        writeEn   = 1'b0;
        writeAddr = '0;
        writeData = '0;
        writeMask = '0;
    endtask

    // Drive one cycle, check the combinational grant mid-cycle, then the
    // registered outputs just after the edge.
    task automatic step(input string name, input logic [3:0] reqs, input logic [23:0] addrs,
                        input logic we, input logic [5:0] wa, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [3:0] efin,
                        input logic [3:0] evalid, input logic [31:0] edata);
        readReqs  = reqs;
        readAddrs = addrs;
        writeEn   = we;
        writeAddr = wa;
        writeData = wd;
        writeMask = wm;
        @(negedge clk);
        chk({name, " readfin"}, 32'(readfin), 32'(efin));
        @(posedge clk);
        #1;
        chk({name, " readValid"}, 32'(readValid), 32'(evalid));
        chk({name, " poolReadData"}, poolReadData, edata);
    endtask

    // Count edges until ready rises while traffic is offered and must be dropped.
    task automatic wait_init(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready) break;
            if (readfin != '0) chk({name, " readfin during init"}, 32'(readfin), 32'h0);
        end
        clear_inputs();
        chk({name, " init cycles"}, 32'(cyc), 32'd64);
    endtask

    // Expected behaviour from the rules: the granted channel is the requester
    // nearest at-or-after the pointer going upward modulo N.
    task automatic model_cycle(input string name, input logic [3:0] reqs, input logic [23:0] addrs,
                               input logic we, input logic [5:0] wa, input logic [31:0] wd,
                               input logic [3:0] wm);
        int g, bestd, d;
        logic [31:0] merged, edata;
        logic [5:0] ag;
        logic [3:0] efin;
        g = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - rr_m + N) % N;
            if (reqs[i] && d < bestd) begin
                bestd = d;
                g = i;
            end
        end
        merged = mem_m[wa];
        for (int b = 0; b < 4; b++) if (wm[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
        efin = '0;
        edata = last_m;
        if (g >= 0) begin
            efin[g] = 1'b1;
            ag = addrs[g*6 +: 6];
            edata = (we && ag == wa) ? merged : mem_m[ag];
        end
        step(name, reqs, addrs, we, wa, wd, wm, efin, efin, edata);
        if (we) mem_m[wa] = merged;
        if (g >= 0) rr_m = (g + 1) % N;
        last_m = edata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [23:0] ra;
        rst = 1'b0;
        readReqs  = 4'hF;
        readAddrs = pk(3, 2, 1, 0);
        writeEn   = 1'b1;
        writeAddr = 6'd5;
        writeData = 32'hFFFF_FFFF;
        writeMask = 4'hF;
        #12;
        chk("reset ready", 32'(ready), 32'h0);
        chk("reset readValid", 32'(readValid), 32'h0);
        chk("reset poolReadData", poolReadData, 32'h0);
        chk("reset readfin", 32'(readfin), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_init("first");

        tbl[0]  = mk(4'b0001, pk(0, 0, 0, 0),   1'b0, 6'd0,  32'h0,         4'h0, 4'b0001, 4'b0001, 32'h0);
        tbl[1]  = mk(4'b0010, pk(0, 0, 37, 0),  1'b0, 6'd0,  32'h0,         4'h0, 4'b0010, 4'b0010, 32'h0);
        tbl[2]  = mk(4'b1000, pk(63, 0, 0, 0),  1'b0, 6'd0,  32'h0,         4'h0, 4'b1000, 4'b1000, 32'h0);
        tbl[3]  = mk(4'b0000, pk(0, 0, 0, 0),   1'b1, 6'd5,  32'hDEADBEEF,  4'hF, 4'b0000, 4'b0000, 32'h0);
        tbl[4]  = mk(4'b0100, pk(0, 5, 0, 0),   1'b0, 6'd0,  32'h0,         4'h0, 4'b0100, 4'b0100, 32'hDEADBEEF);
        tbl[5]  = mk(4'b0001, pk(0, 0, 0, 5),   1'b1, 6'd5,  32'h11223344,  4'b0101, 4'b0001, 4'b0001, 32'hDE22BE44);
        tbl[6]  = mk(4'b0010, pk(0, 0, 5, 0),   1'b0, 6'd0,  32'h0,         4'h0, 4'b0010, 4'b0010, 32'hDE22BE44);
        tbl[7]  = mk(4'b0000, pk(0, 0, 0, 0),   1'b0, 6'd0,  32'h0,         4'h0, 4'b0000, 4'b0000, 32'hDE22BE44);
        tbl[8]  = mk(4'b0000, pk(0, 0, 0, 0),   1'b1, 6'd10, 32'hA5A5A5A5,  4'hF, 4'b0000, 4'b0000, 32'hDE22BE44);
        tbl[9]  = mk(4'b0000, pk(0, 0, 0, 0),   1'b1, 6'd11, 32'h12345678,  4'b0010, 4'b0000, 4'b0000, 32'hDE22BE44);
        tbl[10] = mk(4'b1000, pk(63, 0, 0, 0),  1'b0, 6'd0,  32'h0,         4'h0, 4'b1000, 4'b1000, 32'h0);
        tbl[11] = mk(4'b1111, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b0001, 4'b0001, 32'hA5A5A5A5);
        tbl[12] = mk(4'b1111, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b0010, 4'b0010, 32'h00005600);
        tbl[13] = mk(4'b1111, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b0100, 4'b0100, 32'hDE22BE44);
        tbl[14] = mk(4'b1111, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b1000, 4'b1000, 32'h0);
        tbl[15] = mk(4'b1111, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b0001, 4'b0001, 32'hA5A5A5A5);
        tbl[16] = mk(4'b1000, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b1000, 4'b1000, 32'h0);
        tbl[17] = mk(4'b1010, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b0010, 4'b0010, 32'h00005600);
        tbl[18] = mk(4'b0000, pk(0, 5, 11, 10), 1'b0, 6'd0,  32'h0,         4'h0, 4'b0000, 4'b0000, 32'h00005600);
        tbl[19] = mk(4'b0010, pk(0, 0, 11, 0),  1'b1, 6'd11, 32'hFFFFFFFF,  4'h0, 4'b0010, 4'b0010, 32'h00005600);

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), tbl[i].reqs, tbl[i].addrs, tbl[i].we, tbl[i].wa,
                 tbl[i].wd, tbl[i].wm, tbl[i].efin, tbl[i].evalid, tbl[i].edata);
        end

        for (int r = 0; r < 64; r++) mem_m[r] = '0;
        mem_m[5]  = 32'hDE22BE44;
        mem_m[10] = 32'hA5A5A5A5;
        mem_m[11] = 32'h00005600;
        rr_m   = 2;
        last_m = 32'h00005600;

        for (int c = 0; c < 1500; c++) begin
            ra = pk($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
            model_cycle($sformatf("rand%0d", c), 4'($urandom_range(15)), ra,
                        1'($urandom_range(1)), 6'($urandom_range(7)), $urandom,
                        4'($urandom_range(15)));
        end

        model_cycle("pre-reset", 4'hF, pk(10, 10, 10, 10), 1'b0, 6'd0, 32'h0, 4'h0);

        readReqs  = 4'hF;
        readAddrs = pk(5, 5, 5, 5);
        #3;
        rst = 1'b0;
        #1;
        chk("midrun reset ready", 32'(ready), 32'h0);
        chk("midrun reset readValid", 32'(readValid), 32'h0);
        chk("midrun reset poolReadData", poolReadData, 32'h0);
        chk("midrun reset readfin", 32'(readfin), 32'h0);
        @(negedge clk);
        writeEn   = 1'b1;
        writeAddr = 6'd5;
        writeData = 32'hFFFF_FFFF;
        writeMask = 4'hF;
        rst = 1'b1;
        wait_init("second");
        step("post-reset row5", 4'b0001, pk(0, 0, 0, 5),  1'b0, 6'd0, 32'h0, 4'h0, 4'b0001, 4'b0001, 32'h0);
        step("post-reset row10", 4'b0010, pk(0, 0, 10, 0), 1'b0, 6'd0, 32'h0, 4'h0, 4'b0010, 4'b0010, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
